decode_stage_hz: RTL and testbench

Parametrised successor decode stage for the in-order pipeline. Holds a NUM_REGS x DATA_W register file and a MIPS-format decoder. Contains the ID/EX stage register with valid tracking, load-use interlock, cache-block hold and a bubble counter. Sits between the IF/ID register and the ALU stage; its stall output replaces per-stage enable fan-out.

---
 rtl/decode_pkg.sv | 34 +++
 rtl/regfile_np.sv | 47 ++++
 rtl/decode_stage_hz.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared opcodes, ALU class, FSM states and control bundle for decode_stage_hz.
package decode_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic    wb_en;
    logic    mem_r_en;
    logic    mem_w_en;
    logic    mem_to_reg;
    logic    is_branch;
    logic    is_immediate;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/regfile_np.sv
// Two-read one-write register file, r0 reads zero, indices >= NUM_REGS unimplemented.
// Optional same-cycle write forwarding under DECODE_WB_BYPASS_EN.
module regfile_np
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [REG_IDX_W-1:0] rb,
  output logic [DATA_W-1:0]    rdata_a,
  output logic [DATA_W-1:0]    rdata_b
);

  localparam int unsigned RF_DEPTH = 32;

  logic [DATA_W-1:0] regs [RF_DEPTH];

  function automatic logic in_range(input logic [REG_IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < NUM_REGS);
  endfunction

  // Write port; r0 and out-of-range indices are never stored
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) regs[i] <= '0;
    end else if (wb_en && in_range(wb_reg)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Read ports with optional writeback forwarding
  always_comb begin
    rdata_a = in_range(ra) ? regs[ra] : '0;
    rdata_b = in_range(rb) ? regs[rb] : '0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && in_range(ra) && (wb_reg == ra)) rdata_a = wb_data;
    if (wb_en && in_range(rb) && (wb_reg == rb)) rdata_b = wb_data;
`endif
  end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: register file, MIPS decoder, ID/EX register, load-use
// interlock, cache-miss hold FSM and saturating bubble counter.
// Optional macro: DECODE_WB_BYPASS_EN (writeback forwarding into reads).
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned SIGN_EXT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 instr_valid,
  input  logic [31:0]          instruction,
  input  logic [DATA_W-1:0]    pc_next,
  input  logic                 block_pipe_instr_cache,
  input  logic                 block_pipe_data_cache,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 stall_fetch,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    rega_data,
  output logic [DATA_W-1:0]    regb_data,
  output logic [DATA_W-1:0]    imm_ext,
  output logic [DATA_W-1:0]    pc_next_q,
  output logic [REG_IDX_W-1:0] rega,
  output logic [REG_IDX_W-1:0] regb,
  output logic [REG_IDX_W-1:0] regd,
  output logic                 wb_en_q,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 mem_to_reg,
  output logic                 is_branch,
  output logic                 is_immediate,
  output logic [1:0]           alu_op,
  output logic [5:0]           funct,
  output logic [CNT_W-1:0]     bubble_count
);

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rd;
    ctrl_t                ctrl;
    logic [5:0]           funct;
  } idex_t;

  logic [OPC_W-1:0]     opcode;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic [15:0]          imm;
  ctrl_t                ctrl_c;
  logic [REG_IDX_W-1:0] regd_c;
  logic                 rt_used_c;
  logic [DATA_W-1:0]    rdata_a, rdata_b;
  idex_t                idex_d, idex_q;
  state_e               state_q, state_d;
  logic                 block_c, hold_c, hazard_c, bubble_c;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign imm    = instruction[15:0];

  regfile_np #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .ra      (rs),
    .rb      (rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Instruction decode into control bundle, destination and rt usage
  always_comb begin
    ctrl_c    = '0;
    regd_c    = '0;
    rt_used_c = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_c.wb_en  = 1'b1;
        ctrl_c.alu_op = ALU_FUNCT;
        regd_c        = rd;
        rt_used_c     = 1'b1;
      end
      OP_LW: begin
        ctrl_c.wb_en        = 1'b1;
        ctrl_c.mem_r_en     = 1'b1;
        ctrl_c.mem_to_reg   = 1'b1;
        ctrl_c.is_immediate = 1'b1;
        regd_c              = rt;
      end
      OP_SW: begin
        ctrl_c.mem_w_en     = 1'b1;
        ctrl_c.is_immediate = 1'b1;
        rt_used_c           = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.is_branch = 1'b1;
        ctrl_c.alu_op    = ALU_SUB;
        rt_used_c        = 1'b1;
      end
      OP_ADDI: begin
        ctrl_c.wb_en        = 1'b1;
        ctrl_c.is_immediate = 1'b1;
        regd_c              = rt;
      end
      default: ;
    endcase
  end

  // Next ID/EX contents for an advancing real instruction
  always_comb begin
    idex_d       = '0;
    idex_d.valid = 1'b1;
    idex_d.a     = rdata_a;
    idex_d.b     = rdata_b;
    idex_d.imm   = (SIGN_EXT != 0) ? DATA_W'($signed(imm)) : DATA_W'(imm);
    idex_d.pc    = pc_next;
    idex_d.ra    = rs;
    idex_d.rb    = rt;
    idex_d.rd    = regd_c;
    idex_d.ctrl  = ctrl_c;
    idex_d.funct = instruction[5:0];
  end

  // RUN/HOLD next state; block inputs act in the cycle they rise
  always_comb begin
    state_d = state_q;
    hold_c  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (block_c) begin
          state_d = ST_HOLD;
          hold_c  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (block_c) hold_c  = 1'b1;
        else         state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign block_c  = block_pipe_instr_cache | block_pipe_data_cache;
  assign hazard_c = ex_valid & mem_r_en & (regd != '0) &
                    ((regd == rs) | (rt_used_c & (regd == rt)));
  assign bubble_c = hazard_c & instr_valid & ~hold_c & ~flush;
  assign stall_fetch = hold_c | bubble_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // ID/EX register: reset > flush > hold > bubble/invalid > advance
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      idex_q <= '0;
    end else if (!hold_c) begin
      if (bubble_c || !instr_valid) idex_q <= '0;
      else                          idex_q <= idex_d;
    end
  end

  // Saturating count of load-use bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bubble_c && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  assign ex_valid     = idex_q.valid;
  assign rega_data    = idex_q.a;
  assign regb_data    = idex_q.b;
  assign imm_ext      = idex_q.imm;
  assign pc_next_q    = idex_q.pc;
  assign rega         = idex_q.ra;
  assign regb         = idex_q.rb;
  assign regd         = idex_q.rd;
  assign wb_en_q      = idex_q.ctrl.wb_en;
  assign mem_r_en     = idex_q.ctrl.mem_r_en;
  assign mem_w_en     = idex_q.ctrl.mem_w_en;
  assign mem_to_reg   = idex_q.ctrl.mem_to_reg;
  assign is_branch    = idex_q.ctrl.is_branch;
  assign is_immediate = idex_q.ctrl.is_immediate;
  assign alu_op       = idex_q.ctrl.alu_op;
  assign funct        = idex_q.funct;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz with a scoreboard of expected ID/EX contents.
module tb_decode_stage_hz;

  localparam int unsigned CW = 3;

  logic        clk = 1'b0;
  logic        reset, flush, instr_valid;
  logic [31:0] instruction, pc_next;
  logic        block_pipe_instr_cache, block_pipe_data_cache;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall_fetch, ex_valid;
  logic [31:0] rega_data, regb_data, imm_ext, pc_next_q;
  logic [4:0]  rega, regb, regd;
  logic        wb_en_q, mem_r_en, mem_w_en, mem_to_reg, is_branch, is_immediate;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [CW-1:0] bubble_count;

  decode_stage_hz #(.DATA_W(32), .NUM_REGS(32), .SIGN_EXT(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instr_valid(instr_valid),
    .instruction(instruction), .pc_next(pc_next),
    .block_pipe_instr_cache(block_pipe_instr_cache),
    .block_pipe_data_cache(block_pipe_data_cache),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall_fetch(stall_fetch), .ex_valid(ex_valid),
    .rega_data(rega_data), .regb_data(regb_data), .imm_ext(imm_ext),
    .pc_next_q(pc_next_q), .rega(rega), .regb(regb), .regd(regd),
    .wb_en_q(wb_en_q), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_to_reg(mem_to_reg), .is_branch(is_branch), .is_immediate(is_immediate),
    .alu_op(alu_op), .funct(funct), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ex_valid;
    logic [31:0] a, b, imm, pcq;
    logic [4:0]  ra, rb, rd;
    logic        wb, mr, mw, m2r, br, im;
    logic [1:0]  alu;
    logic [5:0]  fn;
  } idex_t;

  typedef enum {K_ADV, K_BUB, K_HOLD} kind_e;

  idex_t       exp_q[$];
  idex_t       last_exp;
  logic [31:0] mdl [32];
  logic [31:0] pc_ctr;
  logic        stall_obs;
  int          bub_exp;
  int          checks, failures;

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_reg == idx) return wb_data;
`endif
    return mdl[idx];
  endfunction

  // Reference decode of one real instruction
  function automatic idex_t model(input logic [31:0] ins, input logic [31:0] pc);
    idex_t e;
    e          = '0;
    e.ex_valid = 1'b1;
    e.ra       = ins[25:21];
    e.rb       = ins[20:16];
    e.a        = rd_model(ins[25:21]);
    e.b        = rd_model(ins[20:16]);
    e.imm      = {{16{ins[15]}}, ins[15:0]};
    e.pcq      = pc;
    e.fn       = ins[5:0];
    case (ins[31:26])
      6'h00: begin e.rd = ins[15:11]; e.alu = 2'd2; e.wb = 1'b1; end
      6'h23: begin e.rd = ins[20:16]; e.mr = 1'b1; e.m2r = 1'b1; e.wb = 1'b1; e.im = 1'b1; end
      6'h2B: begin e.mw = 1'b1; e.im = 1'b1; end
      6'h04: begin e.br = 1'b1; e.alu = 2'd1; end
      6'h08: begin e.rd = ins[20:16]; e.wb = 1'b1; e.im = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic idex_t sample();
    idex_t s;
    s.ex_valid = ex_valid;  s.a = rega_data;   s.b = regb_data;
    s.imm = imm_ext;        s.pcq = pc_next_q; s.ra = rega;
    s.rb = regb;            s.rd = regd;       s.wb = wb_en_q;
    s.mr = mem_r_en;        s.mw = mem_w_en;   s.m2r = mem_to_reg;
    s.br = is_branch;       s.im = is_immediate;
    s.alu = alu_op;         s.fn = funct;
    return s;
  endfunction

  // Drive one cycle, push the expected ID/EX result, update the reference regfile
  task automatic issue(input kind_e k, input logic v, input logic [31:0] ins);
    idex_t e;
    instr_valid = v;
    instruction = ins;
    pc_next     = pc_ctr;
    #1 stall_obs = stall_fetch;
    if (reset || flush || k == K_BUB) e = '0;
    else if (k == K_HOLD)             e = last_exp;
    else                              e = v ? model(ins, pc_ctr) : '0;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      bub_exp = 0;
    end else if (wb_en && wb_reg != 5'd0) begin
      mdl[wb_reg] = wb_data;
    end
    #1;
    reset = 1'b0; flush = 1'b0; wb_en = 1'b0;
    block_pipe_instr_cache = 1'b0; block_pipe_data_cache = 1'b0;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic test_reset();
    idex_t got, e;
    logic  st [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin reset = 1'b1; issue(K_BUB, 1'b0, 32'd0); end
        1: begin wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'hAAAA;
                 issue(K_ADV, 1'b1, itype(6'h23, 5'd9, 5'd4, 16'd0)); end
        2: begin block_pipe_data_cache = 1'b1; issue(K_HOLD, 1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h20)); end
        3: begin reset = 1'b1; block_pipe_data_cache = 1'b1;
                 issue(K_BUB, 1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h20)); end
        default: issue(K_ADV, 1'b1, rtype(5'd9, 5'd9, 5'd3, 6'h20));
      endcase
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL reset_idex[%0d] got=%h exp=%h", i, got, e); end
      checks++;
      if (stall_obs !== st[i]) begin failures++; $display("FAIL reset_stall[%0d] got=%b exp=%b", i, stall_obs, st[i]); end
    end
    checks++;
    if (bubble_count !== CW'(bub_exp)) begin
      failures++; $display("FAIL reset_count got=%0d exp=%0d", bubble_count, bub_exp);
    end
  endtask

  task automatic test_rtype();
    idex_t got, e;
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    issue(K_ADV, 1'b0, 32'd0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rtype_wb_bubble got=%h exp=%h", got, e); end
    checks++;
    if (stall_obs !== 1'b0) begin failures++; $display("FAIL rtype_invalid_stall got=%b exp=0", stall_obs); end
    issue(K_ADV, 1'b1, rtype(5'd5, 5'd5, 5'd3, 6'h20));
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rtype_add got=%h exp=%h", got, e); end
    checks++;
    if (rega_data !== 32'h1234 || regb_data !== 32'h1234 || alu_op !== 2'd2 || regd !== 5'd3) begin
      failures++;
      $display("FAIL rtype_fields got a=%h b=%h alu=%0d rd=%0d exp a=b=1234 alu=2 rd=3",
               rega_data, regb_data, alu_op, regd);
    end
  endtask

  // Producer lw followed by consumer; stall expected when the consumer reads lw's destination
  task automatic test_load_use(input int reps);
    idex_t got, e;
    logic [31:0] prod [6];
    logic [31:0] cons [6];
    logic        st   [6];
    prod = '{itype(6'h23, 5'd2, 5'd4, 16'h8), itype(6'h23, 5'd2, 5'd4, 16'h8),
             itype(6'h23, 5'd2, 5'd4, 16'h8), itype(6'h23, 5'd2, 5'd4, 16'h8),
             itype(6'h23, 5'd2, 5'd4, 16'h8), itype(6'h23, 5'd2, 5'd0, 16'h0)};
    cons = '{rtype(5'd4, 5'd1, 5'd6, 6'h20), rtype(5'd1, 5'd4, 5'd6, 6'h22),
             itype(6'h2B, 5'd2, 5'd4, 16'h0), itype(6'h08, 5'd2, 5'd4, 16'h5),
             itype(6'h04, 5'd1, 5'd4, 16'h3), rtype(5'd0, 5'd0, 5'd6, 6'h20)};
    st   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < 6; i++) begin
        if (reps > 1 && !st[i]) continue;
        issue(K_ADV, 1'b1, prod[i]);
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL lu_producer[%0d] got=%h exp=%h", i, got, e); end
        issue(st[i] ? K_BUB : K_ADV, 1'b1, cons[i]);
        if (st[i] && bub_exp < 7) bub_exp++;
        checks++;
        if (stall_obs !== st[i]) begin failures++; $display("FAIL lu_stall[%0d] got=%b exp=%b", i, stall_obs, st[i]); end
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL lu_consumer[%0d] got=%h exp=%h", i, got, e); end
        checks++;
        if (bubble_count !== CW'(bub_exp)) begin
          failures++; $display("FAIL lu_count[%0d] got=%0d exp=%0d", i, bubble_count, bub_exp);
        end
        if (st[i]) begin
          issue(K_ADV, 1'b1, cons[i]);
          checks++;
          if (stall_obs !== 1'b0) begin failures++; $display("FAIL lu_release_stall[%0d] got=%b exp=0", i, stall_obs); end
          got = sample(); e = exp_q.pop_front(); checks++;
          if (got !== e) begin failures++; $display("FAIL lu_reissue[%0d] got=%h exp=%h", i, got, e); end
        end
      end
    end
  endtask

  task automatic test_hold();
    idex_t got, e;
    kind_e k  [9] = '{K_ADV, K_HOLD, K_HOLD, K_HOLD, K_ADV, K_ADV, K_HOLD, K_BUB, K_ADV};
    logic  bd [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic  st [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ins [9];
    ins = '{itype(6'h08, 5'd0, 5'd2, 16'h55), rtype(5'd2, 5'd2, 5'd8, 6'h20),
            rtype(5'd2, 5'd2, 5'd8, 6'h20),   rtype(5'd2, 5'd2, 5'd8, 6'h20),
            rtype(5'd2, 5'd2, 5'd8, 6'h20),   itype(6'h23, 5'd1, 5'd4, 16'h0),
            rtype(5'd4, 5'd1, 5'd6, 6'h20),   rtype(5'd4, 5'd1, 5'd6, 6'h20),
            rtype(5'd4, 5'd1, 5'd6, 6'h20)};
    for (int i = 0; i < 9; i++) begin
      block_pipe_data_cache = bd[i];
      issue(k[i], 1'b1, ins[i]);
      if (k[i] == K_BUB && bub_exp < 7) bub_exp++;
      checks++;
      if (stall_obs !== st[i]) begin failures++; $display("FAIL hold_stall[%0d] got=%b exp=%b", i, stall_obs, st[i]); end
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL hold_idex[%0d] got=%h exp=%h", i, got, e); end
      checks++;
      if (bubble_count !== CW'(bub_exp)) begin
        failures++; $display("FAIL hold_count[%0d] got=%0d exp=%0d", i, bubble_count, bub_exp);
      end
    end
  endtask

  task automatic test_flush();
    idex_t got, e;
    kind_e k  [5] = '{K_BUB, K_ADV, K_BUB, K_HOLD, K_ADV};
    logic  fl [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic  bi [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic  st [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ins [5];
    ins = '{itype(6'h23, 5'd2, 5'd4, 16'h8), rtype(5'd4, 5'd1, 5'd6, 6'h20),
            itype(6'h23, 5'd2, 5'd4, 16'h8), rtype(5'd4, 5'd1, 5'd6, 6'h20),
            rtype(5'd4, 5'd1, 5'd6, 6'h20)};
    for (int i = 0; i < 5; i++) begin
      flush = fl[i];
      block_pipe_instr_cache = bi[i];
      issue(k[i], 1'b1, ins[i]);
      checks++;
      if (stall_obs !== st[i]) begin failures++; $display("FAIL flush_stall[%0d] got=%b exp=%b", i, stall_obs, st[i]); end
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL flush_idex[%0d] got=%h exp=%h", i, got, e); end
    end
    checks++;
    if (bubble_count !== CW'(bub_exp)) begin
      failures++; $display("FAIL flush_count got=%0d exp=%0d", bubble_count, bub_exp);
    end
  endtask

  task automatic test_bypass_imm();
    idex_t got, e;
    logic [31:0] want;
`ifdef DECODE_WB_BYPASS_EN
    want = 32'h2222;
`else
    want = 32'h1111;
`endif
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h1111; issue(K_ADV, 1'b0, 32'd0); end
        1: begin wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h2222;
                 issue(K_ADV, 1'b1, rtype(5'd7, 5'd0, 5'd8, 6'h20)); end
        2: issue(K_ADV, 1'b1, rtype(5'd7, 5'd7, 5'd8, 6'h20));
        3: issue(K_ADV, 1'b1, itype(6'h08, 5'd0, 5'd2, 16'hFFFF));
        default: issue(K_ADV, 1'b1, itype(6'h3F, 5'd7, 5'd2, 16'h7FFF));
      endcase
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL byp_imm_idex[%0d] got=%h exp=%h", i, got, e); end
      if (i == 1) begin
        checks++;
        if (rega_data !== want) begin failures++; $display("FAIL same_cycle_read got=%h exp=%h", rega_data, want); end
      end
      if (i == 3) begin
        checks++;
        if (imm_ext !== 32'hFFFF_FFFF) begin failures++; $display("FAIL imm_sext got=%h exp=ffffffff", imm_ext); end
      end
    end
  endtask

  task automatic test_back_to_back();
    idex_t got, e;
    logic [5:0]  ops [5] = '{6'h00, 6'h08, 6'h2B, 6'h04, 6'h11};
    logic [31:0] ins;
    for (int i = 0; i < 12; i++) begin
      ins = itype(ops[$urandom_range(4, 0)], 5'($urandom_range(31, 0)),
                  5'($urandom_range(31, 0)), 16'($urandom));
      wb_en = 1'($urandom_range(1, 0));
      wb_reg = 5'($urandom_range(31, 0));
      wb_data = $urandom;
      issue(K_ADV, 1'b1, ins);
      checks++;
      if (stall_obs !== 1'b0) begin failures++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, stall_obs); end
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL b2b_idex[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; bub_exp = 0; pc_ctr = 32'h100; last_exp = '0;
    reset = 1'b0; flush = 1'b0; instr_valid = 1'b0; instruction = '0; pc_next = '0;
    block_pipe_instr_cache = 1'b0; block_pipe_data_cache = 1'b0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    #1;
    test_reset();
    test_rtype();
    test_load_use(1);
    test_hold();
    test_flush();
    test_load_use(2);
    test_bypass_imm();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
